operand_fetch: RTL
==================

// Module: operand_fetch
// PURPOSE
//  Read side of the 16-bit register bank: turns a register-read request (rs1, rs2, rd) into a registered operand pair for the ALU stage.
//  Reads every register's raw Q output and forwards same-cycle write-back data (the registers' write bypass, reproduced on the read side).
//  Holds a busy scoreboard so no operand is issued while its producer is still in flight.
//  Sits between decode (upstream) and the ALU/execute stage (downstream), in front of the register bank.
// PARAMETERS
//  DW    16  data width of each register / operand
//  NREG  16  number of registers in the bank
//  AW    4   register address width, must equal clog2(NREG)
// PORTS
//  clk        in   1         clock, rising edge
//  rst_b      in   1         asynchronous reset, active low
//  rf_q       in   NREG*DW   raw register Q outputs, register i at [i*DW +: DW], no bypass applied
//  wb_en      in   1         write-back this cycle (same strobe as register en)
//  wb_addr    in   AW        write-back destination
//  wb_data    in   DW        write-back data
//  req_valid  in   1         decode presents a request
//  req_ready  out  1         request accepted this cycle when req_valid && req_ready
//  req_rs1    in   AW        source A address
//  req_rs2    in   AW        source B address
//  req_rd     in   AW        destination address
//  req_wr     in   1         instruction will write req_rd
//  out_valid  out  1         operand pair valid toward execute
//  out_ready  in   1         execute consumes when out_valid && out_ready
//  out_a      out  DW        operand A
//  out_b      out  DW        operand B
//  out_rd     out  AW        forwarded destination
//  out_wr     out  1         forwarded write flag
//  busy       out  NREG      scoreboard, bit i = register i has a write pending
// BEHAVIOUR
//  - Reset (rst_b=0, async): state=EMPTY; out_valid, out_a, out_b, out_rd, out_wr and busy are all 0.
//  - Operand selection (combinational): srcX = (wb_en && wb_addr==rsX) ? wb_data : rf_q[rsX].
//  - Hazard: hzX = busy[rsX] && !(wb_en && wb_addr==rsX).
//    hz_rd = req_wr && busy[req_rd] && !(wb_en && wb_addr==req_rd) (WAW).
//    stall = hz1 | hz2 | hz_rd.
//  - FSM, 2 states:
//    - EMPTY: req_ready = !stall. On accept, latch srcA/srcB/rd/wr and go to FULL.
//    - FULL: req_ready = out_ready && !stall.
//      - out_ready with accept: reload the output register and stay FULL.
//      - out_ready without accept: go to EMPTY.
//      - !out_ready: outputs hold stable.
//  - out_valid = (state==FULL). Latency: request accepted in cycle N gives out_valid in cycle N+1.
//  - Outputs never change while out_valid && !out_ready.
//  - Scoreboard, evaluated per cycle:
//    - wb_en clears busy[wb_addr].
//    - Accept with req_wr sets busy[req_rd].
//    - Set and clear on the same bit in the same cycle: set wins (the new producer).
//  - wb_en to a non-busy register is legal; it leaves busy unchanged.
//  - rs1==rs2 is legal; both operands get the same value.
//  - A request whose rd equals one of its own sources is legal; the sources read before busy is set.
//  - No register is hardwired to zero.
//  - Reset mid-operation: the in-flight operand is dropped and the scoreboard is cleared. The upstream must reissue.
//  - req_ready depends combinationally on req_* and wb_*. Upstream must not make req_valid depend on req_ready.
// STRUCTURE
//  - Shared package: DW, NREG, AW and the FSM state encoding (ST_EMPTY=1'b0, ST_FULL=1'b1).
//  - One sub-module, rf_read_mux: pure combinational read of one source from rf_q plus write-back forward, instantiated twice (A, B).
//  - Scoreboard and FSM stay in the top module.
// TESTING
//  1. Reset: R3=0x1234 in rf_q, read rs1=3, rs2=3 -> next cycle out_valid=1, out_a=out_b=0x1234, busy=0.
//  2. Bypass: rf_q R5=0x0000, same cycle wb_en=1, wb_addr=5, wb_data=0xBEEF, read rs1=5 -> out_a=0xBEEF.
//  3. RAW stall:
//     - Issue rd=2 wr=1 -> busy[2]=1.
//     - Next request rs1=2 -> req_ready=0 until the cycle wb_addr=2 with wb_data=0x00AA.
//     - It is accepted in that cycle with out_a=0x00AA, and busy[2]=0 afterwards.
//  4. Backpressure: out_ready=0 for 3 cycles with req_valid=1 -> req_ready=0 and out_a/out_b/out_rd stable. out_ready=1 -> one transfer per cycle resumes.
//  5. Set/clear collision:
//     - busy[4]=1.
//     - Same cycle: wb_addr=4 plus accept of a new request with rd=4, wr=1 -> busy[4]=1.
//  6. Async reset asserted while FULL with busy=0x0006 -> out_valid=0 and busy=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared widths and FSM encoding for the operand fetch stage
package operand_fetch_pkg;
  localparam int DW = 16;
  localparam int NREG = 16;
  localparam int AW = 4;
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;
endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: decode request, write-back, register bank and execute-side signals
interface operand_fetch_if;
  import operand_fetch_pkg::*;
  logic [NREG*DW-1:0] rf_q;
  logic               wb_en;
  logic [AW-1:0]      wb_addr;
  logic [DW-1:0]      wb_data;
  logic               req_valid;
  logic               req_ready;
  logic [AW-1:0]      req_rs1;
  logic [AW-1:0]      req_rs2;
  logic [AW-1:0]      req_rd;
  logic               req_wr;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_a;
  logic [DW-1:0]      out_b;
  logic [AW-1:0]      out_rd;
  logic               out_wr;
  logic [NREG-1:0]    busy;
  modport slave (
    input  rf_q, wb_en, wb_addr, wb_data, req_valid, req_rs1, req_rs2, req_rd, req_wr, out_ready,
    output req_ready, out_valid, out_a, out_b, out_rd, out_wr, busy
  );
  modport master (
    output rf_q, wb_en, wb_addr, wb_data, req_valid, req_rs1, req_rs2, req_rd, req_wr, out_ready,
    input  req_ready, out_valid, out_a, out_b, out_rd, out_wr, busy
  );
endinterface

// File: rtl/operand_fetch_rf_read_mux.sv
// rf_read_mux: reads one source from the raw bank and forwards same-cycle write-back
module rf_read_mux
  import operand_fetch_pkg::*;
(
  input  logic [NREG*DW-1:0] i_rf_q,
  input  logic [AW-1:0]      i_rs,
  input  logic               i_wb_en,
  input  logic [AW-1:0]      i_wb_addr,
  input  logic [DW-1:0]      i_wb_data,
  output logic [DW-1:0]      o_src
);
  assign o_src = (i_wb_en && i_wb_addr == i_rs) ? i_wb_data : i_rf_q[i_rs*DW +: DW];
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: hazard-checked operand read with a one-entry output register and busy scoreboard
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_b,
  operand_fetch_if.slave  bus
);
  state_t          r_state;
  logic [DW-1:0]   r_a, r_b;
  logic [AW-1:0]   r_rd;
  logic            r_wr;
  logic [NREG-1:0] r_busy;
  logic [DW-1:0]   w_src_a, w_src_b;
  logic            w_hz1, w_hz2, w_hz_rd, w_stall, w_acc;
  logic [NREG-1:0] w_clr, w_set;

  rf_read_mux u_mux_a (
    .i_rf_q(bus.rf_q), .i_rs(bus.req_rs1), .i_wb_en(bus.wb_en),
    .i_wb_addr(bus.wb_addr), .i_wb_data(bus.wb_data), .o_src(w_src_a)
  );
  rf_read_mux u_mux_b (
    .i_rf_q(bus.rf_q), .i_rs(bus.req_rs2), .i_wb_en(bus.wb_en),
    .i_wb_addr(bus.wb_addr), .i_wb_data(bus.wb_data), .o_src(w_src_b)
  );

  // a write-back landing this cycle resolves the hazard on its register
  assign w_hz1   = r_busy[bus.req_rs1] && !(bus.wb_en && bus.wb_addr == bus.req_rs1);
  assign w_hz2   = r_busy[bus.req_rs2] && !(bus.wb_en && bus.wb_addr == bus.req_rs2);
  assign w_hz_rd = bus.req_wr && r_busy[bus.req_rd] && !(bus.wb_en && bus.wb_addr == bus.req_rd);
  assign w_stall = w_hz1 | w_hz2 | w_hz_rd;
  assign bus.req_ready = !w_stall && (r_state == ST_EMPTY || bus.out_ready);
  assign w_acc   = bus.req_valid && bus.req_ready;
  assign w_clr   = bus.wb_en ? NREG'(1) << bus.wb_addr : '0;
  assign w_set   = (w_acc && bus.req_wr) ? NREG'(1) << bus.req_rd : '0;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_EMPTY;
      r_a     <= '0;
      r_b     <= '0;
      r_rd    <= '0;
      r_wr    <= 1'b0;
      r_busy  <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
      if (w_acc) begin
        r_state <= ST_FULL;
        r_a     <= w_src_a;
        r_b     <= w_src_b;
        r_rd    <= bus.req_rd;
        r_wr    <= bus.req_wr;
      end else if (r_state == ST_FULL && bus.out_ready) begin
        r_state <= ST_EMPTY;
      end
    end
  end

  assign bus.out_valid = r_state == ST_FULL;
  assign bus.out_a     = r_a;
  assign bus.out_b     = r_b;
  assign bus.out_rd    = r_rd;
  assign bus.out_wr    = r_wr;
  assign bus.busy      = r_busy;
endmodule
